pwl_activation: RTL
===================

Name: pwl_activation

Overview:
- Pipelined piecewise-linear activation evaluator; sits directly downstream of the 32-segment threshold comparator in the neuron datapath.
- Takes the neuron accumulator value A and the comparator's 5-bit segment index.
- Looks up a per-segment slope and intercept from a run-time-writable 32-entry coefficient table.
- Computes y = sat((slope*A) >>> SlopeFrac + intercept), with valid/ready flow control on the output.

Parameters:
- Width, 24, signed width of A, intercept and Y.
- CoefWidth, 16, signed width of slope entries.
- SlopeFrac, 14, fractional bits of slope (16384 = 1.0).

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RST_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/Seg pair presented.
- in_ready  output  1  block accepts pair this cycle.
- A  input  Width  signed accumulator value (same A fed to comparator).
- Seg  input  5  segment index from comparator.
- out_valid  output  1  Y valid.
- out_ready  input  1  downstream accepts Y.
- Y  output  Width  signed activation result.
- cfg_we  input  1  coefficient write strobe.
- cfg_sel  input  1  0 = slope table, 1 = intercept table.
- cfg_addr  input  5  table entry.
- cfg_data  input  Width  write data; slope uses low CoefWidth bits.

Behaviour:
- Reset (async, RST_n=0):
  - all stage valids 0; out_valid=0; Y=0.
  - all 32 slopes and intercepts = 0.
  - in_ready=1 as soon as reset releases.
- Pipeline: 3 register stages; global advance = out_ready | ~out_valid; in_ready = advance.
- Transfer rules:
  - A sample is accepted when in_valid & in_ready.
  - Y is consumed when out_valid & out_ready.
- Stage 1: register A, slope[Seg], intercept[Seg], valid.
- Stage 2: signed product P = A * slope, width Width+CoefWidth (40), no overflow possible.
- Stage 3: S = (P >>> SlopeFrac) + sign-extended intercept, computed in Width+CoefWidth+1 bits.
  - Y saturates: S > 2^(Width-1)-1 gives 2^(Width-1)-1; S < -2^(Width-1) gives -2^(Width-1).
  - The shift is arithmetic and truncates toward minus infinity.
- Latency: exactly 3 cycles from acceptance to out_valid when out_ready is held 1; throughput 1 sample/cycle.
- Stall: while advance=0, every stage register holds, including Y; bubbles are not squeezed.
- Config write: takes effect on the CLK edge where cfg_we=1, independent of stalls.
- Write/read collision: a write to the entry being read by a sample accepted in the same cycle yields the OLD coefficient; the next accepted sample sees the new one.
- Mid-operation reset: in-flight samples are discarded and the coefficient tables are cleared; software must reload.
- Seg values 0..31 are all valid; no out-of-range case exists.

Optional Feature:
- Macro PWL_ROUND_EN.
- Defined: stage 3 adds 2^(SlopeFrac-1) to P before the shift (round half up); latency unchanged.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- Reset then load slope[5]=8192, intercept[5]=2048; apply A=4096, Seg=5, out_ready=1 -> Y=4096 exactly 3 cycles after acceptance; in_ready held 1.
- slope[31]=32767, intercept[31]=0; A=8388607, Seg=31 -> Y=8388607 (positive saturation). Same slope with A=-8388608 -> Y=-8388608.
- slope[0]=1, intercept[0]=0; A=8193 -> Y=0 without PWL_ROUND_EN, Y=1 with it. A=-1 -> Y=-1 without, Y=0 with.
- Stream of 6 back-to-back samples with out_ready low for cycles 4-6:
  - Y and out_valid hold during the stall; in_ready=0 during the stall.
  - no sample is lost or duplicated; output order is preserved.
- Write intercept[3]=100 in the same cycle a Seg=3 sample is accepted (old value 0) -> that sample uses 0; the following Seg=3 sample uses 100.
- Assert RST_n=0 asynchronously with 3 samples in flight -> out_valid drops immediately and no stale Y appears after release; a subsequent sample yields intercept-only 0 until the tables are reloaded.

Source files
------------

// File: rtl/pwl_activation.sv
// Three-stage piecewise-linear activation: y = sat((slope[seg]*A) >>> SlopeFrac + intercept[seg]).
// Optional PWL_ROUND_EN adds half an LSB before the shift (round half up) instead of truncating.
module pwl_activation #(
    parameter int Width     = 24,
    parameter int CoefWidth = 16,
    parameter int SlopeFrac = 14
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] A,
    input  logic [4:0]       Seg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] Y,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [4:0]       cfg_addr,
    input  logic [Width-1:0] cfg_data
);
    localparam int PW = Width + CoefWidth;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] YMAX = {{(CoefWidth+1){1'b0}}, 1'b0, {(Width-1){1'b1}}};
    localparam logic signed [SW-1:0] YMIN = {{(CoefWidth+1){1'b1}}, 1'b1, {(Width-1){1'b0}}};

    logic signed [CoefWidth-1:0] slope_q [32];
    logic signed [Width-1:0]     icpt_q  [32];

    logic                        v1_q, v2_q, v3_q;
    logic signed [Width-1:0]     a1_q;
    logic signed [CoefWidth-1:0] sl1_q;
    logic signed [Width-1:0]     ic1_q, ic2_q;
    logic signed [PW-1:0]        p2_q, p2_d;
    logic signed [Width-1:0]     y_q, y_d;
    logic signed [SW-1:0]        p_ext, s_sum;
    logic                        advance;

    // Handshake: a sample transfers when in_valid & in_ready, a result when out_valid & out_ready;
    // the whole pipe moves together whenever the output register is empty or being drained.
    assign advance   = out_ready | ~v3_q;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign Y         = y_q;

    // Table writes ignore pipeline stalls; a same-edge read by stage 1 still sees the old entry.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 32; i++) begin
                slope_q[i] <= '0;
                icpt_q[i]  <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_sel) icpt_q[cfg_addr]  <= cfg_data;
            else         slope_q[cfg_addr] <= cfg_data[CoefWidth-1:0];
        end
    end

    always_comb begin
        p2_d  = PW'(a1_q) * PW'(sl1_q);
        p_ext = {p2_q[PW-1], p2_q};
`ifdef PWL_ROUND_EN
        p_ext = p_ext + SW'(2 ** (SlopeFrac - 1));
`endif
        s_sum = (p_ext >>> SlopeFrac) + SW'(ic2_q);
        if (s_sum > YMAX)      y_d = YMAX[Width-1:0];
        else if (s_sum < YMIN) y_d = YMIN[Width-1:0];
        else                   y_d = s_sum[Width-1:0];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            a1_q  <= '0;
            sl1_q <= '0;
            ic1_q <= '0;
            p2_q  <= '0;
            ic2_q <= '0;
            y_q   <= '0;
        end else if (advance) begin
            v1_q  <= in_valid;
            a1_q  <= A;
            sl1_q <= slope_q[Seg];
            ic1_q <= icpt_q[Seg];
            v2_q  <= v1_q;
            p2_q  <= p2_d;
            ic2_q <= ic1_q;
            v3_q  <= v2_q;
            y_q   <= y_d;
        end
    end
endmodule
